// File: rtl/cweight_loader.sv
// Compensation-weight preload sequencer: reads ROWS weights last-row-first from
// the compensation memory and shifts them into the CPE chain head.
module cweight_loader #(
  parameter int ROWS   = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [2:0]        mem_rd_data_i,
  output logic              preload_cweight_o,
  output logic [2:0]        cweight_out_o,
  output logic              cweight_out_valid_o,
  output logic              busy_o,
  output logic              done_o
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | one memory read per cycle, last row first
  // DRAIN | waiting for the final words to leave the read pipeline
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam int CNT_W = $clog2(ROWS + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_vld_q;
  logic              out_vld_q;
  logic [2:0]        wt_q;
  logic              last_rd;
  logic              abort_act;
  logic              start_acc;

  assign last_rd   = (cnt_q == CNT_W'(ROWS - 1));
  assign abort_act = abort_i && (state_q != S_IDLE);
  assign start_acc = (state_q == S_IDLE) && start_i && !abort_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_READ;
      S_READ: begin
        if (abort_i)      state_d = S_IDLE;
        else if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // last word is on the output when nothing more is in flight behind it
        if (abort_i)                      state_d = S_IDLE;
        else if (out_vld_q && !rd_vld_q)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en_o         = (state_q == S_READ);
    mem_addr_o          = (state_q == S_READ) ? addr_q : '0;
    busy_o              = (state_q == S_READ) || (state_q == S_DRAIN);
    preload_cweight_o   = busy_o;
    done_o              = (state_q == S_DONE);
    cweight_out_valid_o = out_vld_q;
    cweight_out_o       = wt_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (start_acc) begin
      cnt_d  = '0;
      addr_d = base_addr_i + ADDR_W'(ROWS - 1);
    end else if (state_q == S_READ) begin
      cnt_d  = cnt_q + CNT_W'(1);
      addr_d = addr_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      wt_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_vld_q  <= mem_rd_en_o && !abort_act;
      out_vld_q <= rd_vld_q && !abort_act;
      if (rd_vld_q && !abort_act) wt_q <= mem_rd_data_i;
    end
  end

endmodule

// File: tb/tb_cweight_loader.sv
// Directed bench for cweight_loader: ROWS=8 and ROWS=1 instances, with a
// scoreboard of expected reads/words/done keyed by cycle number.
module tb_cweight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, abort, start8, start1;
  logic [5:0] base;
  logic       rd8, rd1, pre8, pre1, vld8, vld1, busy8, busy1, done8, done1;
  logic [5:0] addr8, addr1;
  logic [2:0] rdat8 = '0, rdat1 = '0, cw8, cw1;

  cweight_loader #(.ROWS(8), .ADDR_W(6)) u8 (
    .clk(clk), .rst(rst), .start_i(start8), .abort_i(abort), .base_addr_i(base),
    .mem_rd_en_o(rd8), .mem_addr_o(addr8), .mem_rd_data_i(rdat8),
    .preload_cweight_o(pre8), .cweight_out_o(cw8), .cweight_out_valid_o(vld8),
    .busy_o(busy8), .done_o(done8));

  cweight_loader #(.ROWS(1), .ADDR_W(6)) u1 (
    .clk(clk), .rst(rst), .start_i(start1), .abort_i(abort), .base_addr_i(base),
    .mem_rd_en_o(rd1), .mem_addr_o(addr1), .mem_rd_data_i(rdat1),
    .preload_cweight_o(pre1), .cweight_out_o(cw1), .cweight_out_valid_o(vld1),
    .busy_o(busy1), .done_o(done1));

  function automatic int memf(bit s, int a);
    if (s && a == 5) return 3;
    return a & 7;
  endfunction

  always @(posedge clk) begin
    if (rd8) rdat8 <= 3'(memf(1'b0, int'(addr8)));
    if (rd1) rdat1 <= 3'(memf(1'b1, int'(addr1)));
  end

  typedef struct { int cyc; int val; } ent_t;
  ent_t aq[$];
  ent_t wq[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int busy_lo = 1, busy_hi = 0, busy_end = -1, done_cyc = 0;
  bit done_pend = 1'b0;
  bit sel = 1'b0;
  int last_w[2] = '{0, 0};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_load(int s);
    int r, a;
    r = sel ? 1 : 8;
    for (int k = 0; k < r; k++) begin
      a = (int'(base) + r - 1 - k) & 63;
      aq.push_back('{s + k, a});
      wq.push_back('{s + k + 2, memf(sel, a)});
    end
    done_cyc  = s + r + 2;
    done_pend = 1'b1;
    busy_lo   = s;
    busy_hi   = s + r + 1;
    busy_end  = s + r + 2;
  endtask

  task automatic cancel(int c);
    while (aq.size() > 0 && aq[$].cyc > c) void'(aq.pop_back());
    while (wq.size() > 0 && wq[$].cyc > c) void'(wq.pop_back());
    done_pend = 1'b0;
    if (busy_hi > c) busy_hi = c;
    busy_end = c;
  endtask

  task automatic check_now();
    logic rd, vld, dn, bz, pr;
    logic [5:0] ad;
    logic [2:0] cw;
    bit exp_rd, exp_v;
    ent_t e;
    rd = sel ? rd1 : rd8;     ad = sel ? addr1 : addr8;
    vld = sel ? vld1 : vld8;  cw = sel ? cw1 : cw8;
    dn = sel ? done1 : done8; bz = sel ? busy1 : busy8;
    pr = sel ? pre1 : pre8;
    exp_rd = (aq.size() > 0) && (aq[0].cyc == cyc);
    chk("mem_rd_en", 32'(rd), 32'(exp_rd));
    if (exp_rd) begin
      e = aq.pop_front();
      chk("mem_addr", 32'(ad), e.val);
    end
    exp_v = (wq.size() > 0) && (wq[0].cyc == cyc);
    chk("cweight_out_valid", 32'(vld), 32'(exp_v));
    if (exp_v) begin
      e = wq.pop_front();
      chk("cweight_out", 32'(cw), e.val);
      last_w[sel] = e.val;
    end else begin
      chk("cweight_hold", 32'(cw), last_w[sel]);
    end
    chk("done", 32'(dn), 32'(done_pend && cyc == done_cyc));
    chk("busy", 32'(bz), 32'(cyc >= busy_lo && cyc <= busy_hi));
    chk("preload_cweight", 32'(pr), 32'(cyc >= busy_lo && cyc <= busy_hi));
  endtask

  task automatic step();
    logic st;
    st = sel ? start1 : start8;
    if (!rst && abort) begin
      if (cyc <= busy_end) cancel(cyc);
    end else if (!rst && st && cyc > busy_end) begin
      push_load(cyc + 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_now();
  endtask

  task automatic check_zero(bit s);
    chk("rst_mem_rd_en", 32'(s ? rd1 : rd8), 0);
    chk("rst_mem_addr", 32'(s ? addr1 : addr8), 0);
    chk("rst_preload", 32'(s ? pre1 : pre8), 0);
    chk("rst_cweight_out", 32'(s ? cw1 : cw8), 0);
    chk("rst_valid", 32'(s ? vld1 : vld8), 0);
    chk("rst_busy", 32'(s ? busy1 : busy8), 0);
    chk("rst_done", 32'(s ? done1 : done8), 0);
  endtask

  task automatic load(logic [5:0] b, int n);
    base = b;
    if (sel) start1 = 1'b1; else start8 = 1'b1;
    step();
    start1 = 1'b0;
    start8 = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; start8 = 1'b0; start1 = 1'b0; base = '0;
    #12;
    check_zero(1'b0);
    check_zero(1'b1);
    rst = 1'b0;

    // nominal, started on the first edge after reset release
    load(6'h10, 13);
    // address wrap
    load(6'h3C, 13);

    // abort sampled in cycle 5, then a clean reload
    load(6'h10, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (8) step();
    load(6'h08, 13);

    // start held for 20 cycles: second load from the cycle after done
    base = 6'h18;
    start8 = 1'b1;
    repeat (20) step();
    start8 = 1'b0;
    repeat (14) step();

    // asynchronous reset in cycle 4
    load(6'h10, 3);
    #2 rst = 1'b1;
    #1 check_zero(1'b0);
    aq.delete(); wq.delete();
    done_pend = 1'b0; busy_lo = 1; busy_hi = 0; busy_end = -1; last_w[0] = 0;
    step();
    step();
    rst = 1'b0;
    load(6'h22, 13);

    // start and abort together in IDLE: abort wins
    base = 6'h30;
    start8 = 1'b1;
    abort = 1'b1;
    step();
    start8 = 1'b0;
    abort = 1'b0;
    repeat (4) step();

    // ROWS=1
    sel = 1'b1;
    load(6'h05, 5);
    sel = 1'b0;

    chk("reads_outstanding", aq.size(), 0);
    chk("words_outstanding", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
